// File: rtl/spi_sram_m23lc512.sv
// 64 KiB SPI SRAM with the 23LC512 command set. SI is sampled on the rising edge of SCK and SO is launched on the falling edge.
// Read data begins half a clock after the last address bit. HOLD_N low freezes every state bit.
module spi_sram_m23lc512 #(
   parameter int         ADDR_W       = 16,
   parameter int         PAGE_BYTES   = 32,
   parameter logic [1:0] DEFAULT_MODE = 2'b01
) (
   input  logic SCK,
   input  logic RESET,
   input  logic CS_N,
   input  logic SI_SIO0,
   output wire  SO_SIO1,
   input  logic HOLD_N_SIO3
);

   localparam int PW = $clog2(PAGE_BYTES);
   localparam int CW = $clog2(ADDR_W) + 1;

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, RDATA, WDATA, RDMR_OUT, WRMR_IN, IGNORE
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       bit_q;
   logic [6:0]          sh_q;
   logic [7:0]          sh_nxt;
   logic [ADDR_W-1:0]   addr_q, addr_inc;
   logic                rd_q;
   logic [1:0]          mode_q;
   logic                so_q, so_en, out_bit;
   logic                last_bit, sess_rst;
   logic [2:0]          idx;
   logic [7:0]          mem [0:(2**ADDR_W)-1];

   // Raising CS_N aborts the session at once, no matter where SCK is.
   assign sess_rst = RESET | CS_N;
   assign sh_nxt   = {sh_q, SI_SIO0};
   assign last_bit = (state_q == ADDR) ? (bit_q == CW'(ADDR_W - 1)) : (bit_q == CW'(7));
   assign idx      = 3'd7 - bit_q[2:0];

   always_comb begin
      addr_inc = addr_q + ADDR_W'(1);
      if (mode_q == 2'b10)
         addr_inc = {addr_q[ADDR_W-1:PW], addr_q[PW-1:0] + PW'(1)};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = CMD;
         CMD: begin
            if (last_bit) begin
               case (sh_nxt)
                  8'h03, 8'h02: state_d = ADDR;
                  8'h05:        state_d = RDMR_OUT;
                  8'h01:        state_d = WRMR_IN;
                  default:      state_d = IGNORE;
               endcase
            end
         end
         ADDR:    if (last_bit) state_d = rd_q ? RDATA : WDATA;
         RDATA, WDATA: begin
            // Byte mode moves only one byte per command.
            if (last_bit && mode_q == 2'b00) state_d = IGNORE;
         end
         WRMR_IN: if (last_bit) state_d = IGNORE;
         default: state_d = state_q;
      endcase
      if (!HOLD_N_SIO3) state_d = state_q;
   end

   always_ff @(posedge SCK or posedge sess_rst) begin
      if (sess_rst) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge SCK or posedge sess_rst) begin
      if (sess_rst) begin
         bit_q  <= '0;
         sh_q   <= '0;
         addr_q <= '0;
         rd_q   <= 1'b0;
      end else if (HOLD_N_SIO3) begin
         bit_q <= last_bit ? '0 : bit_q + CW'(1);
         sh_q  <= sh_nxt[6:0];
         if (state_q == CMD && last_bit)
            rd_q <= (sh_nxt == 8'h03);
         if (state_q == ADDR)
            addr_q <= {addr_q[ADDR_W-2:0], SI_SIO0};
         else if ((state_q == RDATA || state_q == WDATA) && last_bit)
            addr_q <= addr_inc;
      end
   end

   // The array has no reset, so its contents survive RESET.
   always_ff @(posedge SCK) begin
      if (HOLD_N_SIO3 && state_q == WDATA && last_bit)
         mem[addr_q] <= sh_nxt;
   end

   always_ff @(posedge SCK or posedge RESET) begin
      if (RESET)
         mode_q <= DEFAULT_MODE;
      else if (HOLD_N_SIO3 && state_q == WRMR_IN && last_bit)
         mode_q <= sh_nxt[7:6];
   end

   always_comb begin
      out_bit = 1'b0;
      case (state_q)
         RDATA:    out_bit = mem[addr_q][idx];
         RDMR_OUT: out_bit = (bit_q == CW'(0)) ? mode_q[1] :
                             (bit_q == CW'(1)) ? mode_q[0] : 1'b0;
         default:  out_bit = 1'b0;
      endcase
   end

   // The output enable is also launched on the falling edge. SO therefore stays Z until the first read bit is valid.
   always_ff @(negedge SCK or posedge sess_rst) begin
      if (sess_rst) begin
         so_q  <= 1'b0;
         so_en <= 1'b0;
      end else if (HOLD_N_SIO3) begin
         so_q  <= out_bit;
         so_en <= (state_q == RDATA) || (state_q == RDMR_OUT);
      end
   end

   assign SO_SIO1 = (so_en && HOLD_N_SIO3) ? so_q : 1'bz;

endmodule

// File: tb/tb_spi_sram_m23lc512.sv
// Bench for spi_sram_m23lc512. A byte-level memory and mode model predicts every SO bit.
// The high-impedance state is observed through a pull-up on SO.
module tb_spi_sram_m23lc512;
   logic SCK = 1'b0;
   logic RESET = 1'b0;
   logic CS_N = 1'b1;
   logic SI = 1'b0;
   logic HOLD_N = 1'b1;
   wire  so_w;

   pullup (so_w);

   spi_sram_m23lc512 #(.ADDR_W(16), .PAGE_BYTES(32), .DEFAULT_MODE(2'b01)) dut (
      .SCK(SCK), .RESET(RESET), .CS_N(CS_N), .SI_SIO0(SI),
      .SO_SIO1(so_w), .HOLD_N_SIO3(HOLD_N)
   );

   always #10 SCK = ~SCK;

   int total = 0;
   int bad = 0;
   logic exp_on = 1'b0;
   logic exp_z = 1'b1;
   logic exp_b = 1'b0;
   logic [7:0] mdl [int];
   logic [1:0] mmode = 2'b01;
   logic [7:0] wq [$];
   logic [7:0] rq [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
      end
   endtask

   // With the pull-up in place, a Z on SO reads as 1.
   initial forever begin
      @(posedge SCK);
      if (exp_on) begin
         if (exp_z) check("so_hiz", {31'b0, so_w}, 32'd1);
         else       check("so_bit", {31'b0, so_w}, {31'b0, exp_b});
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] adv(input logic [15:0] a);
      if (mmode == 2'b10) return (a & 16'hFFE0) | ((a + 16'd1) & 16'h001F);
      return a + 16'd1;
   endfunction

   function automatic logic [7:0] mget(input logic [15:0] a);
      if (mdl.exists(int'(a))) return mdl[int'(a)];
      return 8'h00;
   endfunction

   task automatic bit_cyc(input logic si, input logic ez, input logic eb, output logic got);
      @(negedge SCK); #2;
      HOLD_N = 1'b1; CS_N = 1'b0; SI = si; exp_z = ez; exp_b = eb;
      @(posedge SCK); #1;
      got = so_w;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic g;
      for (int j = 7; j >= 0; j--) bit_cyc(b[j], 1'b1, 1'b0, g);
   endtask

   task automatic send_addr(input logic [15:0] a);
      logic g;
      for (int j = 15; j >= 0; j--) bit_cyc(a[j], 1'b1, 1'b0, g);
   endtask

   task automatic end_tx();
      @(negedge SCK); #2;
      CS_N = 1'b1; exp_z = 1'b1; SI = 1'($urandom);
      repeat (2) @(posedge SCK);
   endtask

   task automatic do_hold();
      @(negedge SCK); #2;
      HOLD_N = 1'b0; exp_z = 1'b1; SI = 1'($urandom);
      repeat (4) @(posedge SCK);
   endtask

   task automatic spi_write(input logic [15:0] addr);
      logic [15:0] a;
      a = addr;
      send_byte(8'h02);
      send_addr(addr);
      foreach (wq[i]) begin
         send_byte(wq[i]);
         if (mmode != 2'b00 || i == 0) begin
            mdl[int'(a)] = wq[i];
            a = adv(a);
         end
      end
      end_tx();
   endtask

   task automatic spi_write_abort(input logic [15:0] addr, input logic [7:0] d, input int nbits);
      logic g;
      send_byte(8'h02);
      send_addr(addr);
      for (int j = 7; j > 7 - nbits; j--) bit_cyc(d[j], 1'b1, 1'b0, g);
      end_tx();
   endtask

   task automatic spi_read(input logic [15:0] addr, input int n, input int hold_at);
      logic [15:0] a;
      logic [7:0] ev, gb;
      logic g, live;
      a = addr;
      rq = {};
      gb = 8'h00;
      send_byte(8'h03);
      send_addr(addr);
      for (int i = 0; i < n; i++) begin
         live = (mmode != 2'b00) || (i == 0);
         ev = live ? mget(a) : 8'h00;
         for (int j = 7; j >= 0; j--) begin
            if (i * 8 + (7 - j) == hold_at) do_hold();
            bit_cyc(1'($urandom), !live, ev[j], g);
            gb[j] = g;
         end
         rq.push_back(gb);
         if (live) a = adv(a);
      end
      end_tx();
   endtask

   task automatic rdmr(input int n);
      logic [7:0] ev, gb;
      logic g;
      rq = {};
      gb = 8'h00;
      send_byte(8'h05);
      for (int i = 0; i < n; i++) begin
         ev = {mmode, 6'b0};
         for (int j = 7; j >= 0; j--) begin
            bit_cyc(1'($urandom), 1'b0, ev[j], g);
            gb[j] = g;
         end
         rq.push_back(gb);
      end
      end_tx();
   endtask

   task automatic wrmr(input logic [7:0] v);
      logic g;
      send_byte(8'h01);
      send_byte(v);
      repeat (3) bit_cyc(1'($urandom), 1'b1, 1'b0, g);
      mmode = v[7:6];
      end_tx();
   endtask

   initial begin
      logic [15:0] ra;
      int n, r, h;
      logic g;

      #5 RESET = 1'b1;
      #30 RESET = 1'b0;
      exp_on = 1'b1;

      rdmr(2);
      check("rdmr_reset0", {24'b0, rq[0]}, 32'h40);
      check("rdmr_reset1", {24'b0, rq[1]}, 32'h40);
      wrmr(8'h80);
      rdmr(1);
      check("rdmr_page", {24'b0, rq[0]}, 32'h80);
      wrmr(8'h40);

      wq = {8'hAA, 8'h55, 8'hC3};
      spi_write(16'h1234);
      spi_read(16'h1234, 3, -1);
      check("seq_rd0", {24'b0, rq[0]}, 32'hAA);
      check("seq_rd1", {24'b0, rq[1]}, 32'h55);
      check("seq_rd2", {24'b0, rq[2]}, 32'hC3);

      wq = {8'h11, 8'h22};
      spi_write(16'hFFFF);
      check("mdl_wrap", {24'b0, mget(16'h0000)}, 32'h22);
      spi_read(16'h0000, 1, -1);
      check("wrap_rd0000", {24'b0, rq[0]}, 32'h22);
      spi_read(16'hFFFF, 2, -1);
      check("wrap_rdFFFF", {24'b0, rq[0]}, 32'h11);
      check("wrap_rd_next", {24'b0, rq[1]}, 32'h22);

      wrmr(8'h80);
      wq = {8'h01, 8'h02, 8'h03};
      spi_write(16'h003E);
      check("mdl_page20", {24'b0, mget(16'h0020)}, 32'h03);
      spi_read(16'h003E, 3, -1);
      check("page_rd2", {24'b0, rq[2]}, 32'h03);
      wrmr(8'h40);
      spi_read(16'h0020, 1, -1);
      check("page_rd20", {24'b0, rq[0]}, 32'h03);

      wq = {8'h5A};
      spi_write(16'h0101);
      wrmr(8'h00);
      wq = {8'h77, 8'h88};
      spi_write(16'h0100);
      spi_read(16'h0100, 2, -1);
      check("byte_rd0", {24'b0, rq[0]}, 32'h77);
      wrmr(8'h40);
      spi_read(16'h0100, 2, -1);
      check("byte_keep0101", {24'b0, rq[1]}, 32'h5A);

      wq = {8'h3C};
      spi_write(16'h0200);
      spi_write_abort(16'h0200, 8'hC3, 5);
      spi_read(16'h0200, 1, -1);
      check("abort_keep", {24'b0, rq[0]}, 32'h3C);

      wq = {8'hA5, 8'h0F, 8'hF0, 8'h96};
      spi_write(16'h0300);
      spi_read(16'h0300, 4, 11);
      check("hold_rd0", {24'b0, rq[0]}, 32'hA5);
      check("hold_rd1", {24'b0, rq[1]}, 32'h0F);
      check("hold_rd2", {24'b0, rq[2]}, 32'hF0);
      check("hold_rd3", {24'b0, rq[3]}, 32'h96);

      wq = {8'h00};
      spi_write(16'h2000);
      wrmr(8'h80);
      send_byte(8'h03);
      send_addr(16'h2000);
      repeat (3) bit_cyc(1'b0, 1'b0, 1'b0, g);
      @(negedge SCK); #2;
      RESET = 1'b1; exp_z = 1'b1;
      #1 check("so_hiz_on_reset", {31'b0, so_w}, 32'd1);
      mmode = 2'b01;
      #5 CS_N = 1'b1;
      @(posedge SCK); #5 RESET = 1'b0;
      rdmr(1);
      check("rdmr_after_reset", {24'b0, rq[0]}, 32'h40);
      spi_read(16'h1234, 1, -1);
      check("mem_retained", {24'b0, rq[0]}, 32'hAA);

      wq = {};
      for (int i = 0; i < 128; i++) wq.push_back(8'($urandom));
      spi_write(16'h7F00);
      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 9);
         ra = 16'h7F00 + 16'($urandom_range(0, 112));
         n = $urandom_range(1, 8);
         if (r == 0) begin
            wrmr({2'($urandom_range(0, 3)), 6'($urandom)});
         end else if (r < 5) begin
            wq = {};
            for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
            spi_write(ra);
         end else begin
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n * 8 - 1) : -1;
            spi_read(ra, n, h);
         end
      end

      exp_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
